// File: rtl/writeback_arbiter_if.sv
// Execution-unit result ports and register-file write ports of the writeback arbiter.
// The slave modport is the arbiter's view; master is the environment (units + register files).
interface writeback_arbiter_if #(
    parameter int RS_ID_WIDTH = 5
);
    // IBM numbering: xer bit 0 is the MSB, i.e. xer[31] here.
    typedef struct packed {
        logic [31:0] xer;
        logic        xer_valid;
        logic        so;
        logic        cr0_valid;
    } cond_exception_t;

    logic                   in0_valid;
    logic                   in0_ready;
    logic [RS_ID_WIDTH-1:0] in0_rs_id;
    logic [4:0]             in0_reg_addr;
    logic [31:0]            in0_result;
    cond_exception_t        in0_cr0_xer;

    logic                   in1_valid;
    logic                   in1_ready;
    logic [RS_ID_WIDTH-1:0] in1_rs_id;
    logic [4:0]             in1_reg_addr;
    logic [31:0]            in1_result;
    cond_exception_t        in1_cr0_xer;

    logic                   wb_ready;
    logic                   gpr_we;
    logic [4:0]             gpr_addr;
    logic [31:0]            gpr_data;
    logic                   cr0_we;
    logic [3:0]             cr0;
    logic                   xer_we;
    logic [31:0]            xer_data;
    logic                   done_valid;
    logic [RS_ID_WIDTH-1:0] done_rs_id;

    modport slave (
        input  in0_valid, in0_rs_id, in0_reg_addr, in0_result, in0_cr0_xer,
        input  in1_valid, in1_rs_id, in1_reg_addr, in1_result, in1_cr0_xer,
        input  wb_ready,
        output in0_ready, in1_ready,
        output gpr_we, gpr_addr, gpr_data, cr0_we, cr0, xer_we, xer_data,
        output done_valid, done_rs_id
    );

    modport master (
        output in0_valid, in0_rs_id, in0_reg_addr, in0_result, in0_cr0_xer,
        output in1_valid, in1_rs_id, in1_reg_addr, in1_result, in1_cr0_xer,
        output wb_ready,
        input  in0_ready, in1_ready,
        input  gpr_we, gpr_addr, gpr_data, cr0_we, cr0, xer_we, xer_data,
        input  done_valid, done_rs_id
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges two execution-unit result streams into an in-order buffer and retires one
// result per cycle to the GPR/CR0/XER write ports, releasing the reservation-station tag.
module writeback_arbiter #(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // cr0 is {LT, GT, EQ, SO}: IBM CR bit 0 (LT) sits in the MSB.
    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             reg_addr;
        logic [31:0]            result;
        logic [3:0]             cr0;
        logic                   cr0_valid;
        logic [31:0]            xer;
        logic                   xer_valid;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      in_entry;
    entry_t      head;
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic        prio;
    logic        full;
    logic        empty;
    logic        push0;
    logic        push1;
    logic        push;
    logic        pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Handshake: a result transfers on a rising edge where inX_valid and inX_ready are both
    // high; sources hold valid and payload until then. Ready never looks at wb_ready, and
    // with both sources valid only the one that prio points at sees ready.
    assign bus.in0_ready = ~rst & ~full & (~bus.in1_valid | ~prio);
    assign bus.in1_ready = ~rst & ~full & (~bus.in0_valid | prio);

    assign push0 = bus.in0_valid & bus.in0_ready;
    assign push1 = bus.in1_valid & bus.in1_ready;
    assign push  = push0 | push1;
    assign pop   = ~empty & bus.wb_ready;
    assign head  = mem[rd_ptr];

    always_comb begin
        in_entry = '0;
        if (push1) begin
            in_entry.rs_id     = bus.in1_rs_id;
            in_entry.reg_addr  = bus.in1_reg_addr;
            in_entry.result    = bus.in1_result;
            in_entry.cr0_valid = bus.in1_cr0_xer.cr0_valid;
            in_entry.xer       = bus.in1_cr0_xer.xer;
            in_entry.xer_valid = bus.in1_cr0_xer.xer_valid;
            in_entry.cr0[0]    = bus.in1_cr0_xer.so;
        end else begin
            in_entry.rs_id     = bus.in0_rs_id;
            in_entry.reg_addr  = bus.in0_reg_addr;
            in_entry.result    = bus.in0_result;
            in_entry.cr0_valid = bus.in0_cr0_xer.cr0_valid;
            in_entry.xer       = bus.in0_cr0_xer.xer;
            in_entry.xer_valid = bus.in0_cr0_xer.xer_valid;
            in_entry.cr0[0]    = bus.in0_cr0_xer.so;
        end
        in_entry.cr0[3] = in_entry.result[31];
        in_entry.cr0[2] = ~in_entry.result[31] & (|in_entry.result);
        in_entry.cr0[1] = ~(|in_entry.result);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            prio   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // After a contended push, prio points at the source that lost.
            if (bus.in0_valid & bus.in1_valid & push) begin
                prio <= ~prio;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gpr_we     <= 1'b0;
            bus.gpr_addr   <= '0;
            bus.gpr_data   <= '0;
            bus.cr0_we     <= 1'b0;
            bus.cr0        <= '0;
            bus.xer_we     <= 1'b0;
            bus.xer_data   <= '0;
            bus.done_valid <= 1'b0;
            bus.done_rs_id <= '0;
        end else begin
            bus.gpr_we     <= pop;
            bus.cr0_we     <= pop & head.cr0_valid;
            bus.xer_we     <= pop & head.xer_valid;
            bus.done_valid <= pop;
            if (pop) begin
                bus.gpr_addr   <= head.reg_addr;
                bus.gpr_data   <= head.result;
                bus.cr0        <= head.cr0;
                bus.xer_data   <= head.xer;
                bus.done_rs_id <= head.rs_id;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of acceptance order and retirement.
module tb_writeback_arbiter;
    localparam int RS_ID_WIDTH = 5;
    localparam int DEPTH       = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.RS_ID_WIDTH(RS_ID_WIDTH)) bus ();

    writeback_arbiter #(.RS_ID_WIDTH(RS_ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [4:0]  rs_id;
        logic [4:0]  reg_addr;
        logic [31:0] result;
        logic [31:0] xer;
        logic        xer_valid;
        logic        so;
        logic        cr0_valid;
    } tx_t;

    typedef struct packed {
        logic        gpr_we;
        logic [4:0]  gpr_addr;
        logic [31:0] gpr_data;
        logic        cr0_we;
        logic [3:0]  cr0;
        logic        xer_we;
        logic [31:0] xer_data;
        logic        done_valid;
        logic [4:0]  done_rs_id;
    } out_t;

    tx_t  src_q0[$];
    tx_t  src_q1[$];
    tx_t  exp_q[$];
    logic m_prio;
    out_t m_out;
    out_t act_out;
    logic [1:0] act_rdy;
    logic [1:0] exp_rdy;
    logic acc0, acc1;
    int   start_pct = 100;
    bit   wb_random = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- clock / reset helpers ----------------
    function automatic tx_t mk(input logic [4:0] rs, input logic [4:0] ra, input logic [31:0] res,
                               input logic [31:0] xer, input logic xv, input logic so, input logic cv);
        tx_t t;
        t.rs_id = rs; t.reg_addr = ra; t.result = res; t.xer = xer;
        t.xer_valid = xv; t.so = so; t.cr0_valid = cv;
        return t;
    endfunction

    function automatic tx_t rand_tx();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0:       r = 32'h0;
            1:       r = 32'h8000_0000 | $urandom();
            default: r = {1'b0, 31'($urandom())};
        endcase
        return mk(5'($urandom()), 5'($urandom()), r, $urandom(),
                  1'($urandom()), 1'($urandom()), 1'($urandom()));
    endfunction

    // CR0 from the signed value of the result, as the architecture defines it.
    function automatic logic [3:0] cr0_of(input tx_t t);
        return {($signed(t.result) < 0), ($signed(t.result) > 0), (t.result == 32'h0), t.so};
    endfunction

    task automatic reset_model();
        exp_q.delete();
        src_q0.delete();
        src_q1.delete();
        m_prio = 1'b0;
        m_out  = '0;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic sample_out();
        act_out.gpr_we     = bus.gpr_we;
        act_out.gpr_addr   = bus.gpr_addr;
        act_out.gpr_data   = bus.gpr_data;
        act_out.cr0_we     = bus.cr0_we;
        act_out.cr0        = bus.cr0;
        act_out.xer_we     = bus.xer_we;
        act_out.xer_data   = bus.xer_data;
        act_out.done_valid = bus.done_valid;
        act_out.done_rs_id = bus.done_rs_id;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_sources(input bit hold0, input bit hold1);
        if (src_q0.size() > 0 && (hold0 || $urandom_range(1, 100) <= start_pct)) begin
            bus.in0_valid = 1'b1;
            bus.in0_rs_id = src_q0[0].rs_id;
            bus.in0_reg_addr = src_q0[0].reg_addr;
            bus.in0_result = src_q0[0].result;
            bus.in0_cr0_xer.xer = src_q0[0].xer;
            bus.in0_cr0_xer.xer_valid = src_q0[0].xer_valid;
            bus.in0_cr0_xer.so = src_q0[0].so;
            bus.in0_cr0_xer.cr0_valid = src_q0[0].cr0_valid;
        end else begin
            bus.in0_valid = 1'b0;
            bus.in0_result = $urandom();
        end
        if (src_q1.size() > 0 && (hold1 || $urandom_range(1, 100) <= start_pct)) begin
            bus.in1_valid = 1'b1;
            bus.in1_rs_id = src_q1[0].rs_id;
            bus.in1_reg_addr = src_q1[0].reg_addr;
            bus.in1_result = src_q1[0].result;
            bus.in1_cr0_xer.xer = src_q1[0].xer;
            bus.in1_cr0_xer.xer_valid = src_q1[0].xer_valid;
            bus.in1_cr0_xer.so = src_q1[0].so;
            bus.in1_cr0_xer.cr0_valid = src_q1[0].cr0_valid;
        end else begin
            bus.in1_valid = 1'b0;
            bus.in1_result = $urandom();
        end
    endtask

    // One clock: model predicts readies before the edge and the write ports after it.
    task automatic cycle();
        bit full, pop, hold0, hold1;
        tx_t t;
        @(negedge clk);
        act_rdy = {bus.in1_ready, bus.in0_ready};
        full = (exp_q.size() == DEPTH);
        exp_rdy[0] = !full && (!bus.in1_valid || m_prio == 1'b0);
        exp_rdy[1] = !full && (!bus.in0_valid || m_prio == 1'b1);
        acc0 = bus.in0_valid && exp_rdy[0];
        acc1 = bus.in1_valid && exp_rdy[1];
        pop = (exp_q.size() > 0) && bus.wb_ready;
        m_out.gpr_we = 1'b0;
        m_out.cr0_we = 1'b0;
        m_out.xer_we = 1'b0;
        m_out.done_valid = 1'b0;
        if (pop) begin
            t = exp_q.pop_front();
            m_out = '{gpr_we: 1'b1, gpr_addr: t.reg_addr, gpr_data: t.result,
                      cr0_we: t.cr0_valid, cr0: cr0_of(t), xer_we: t.xer_valid,
                      xer_data: t.xer, done_valid: 1'b1, done_rs_id: t.rs_id};
        end
        if (acc0) exp_q.push_back(src_q0[0]);
        else if (acc1) exp_q.push_back(src_q1[0]);
        if (bus.in0_valid && bus.in1_valid && (acc0 || acc1)) m_prio = ~m_prio;
        @(posedge clk);
        #1;
        sample_out();
        hold0 = bus.in0_valid && !acc0;
        hold1 = bus.in1_valid && !acc1;
        if (acc0) void'(src_q0.pop_front());
        if (acc1) void'(src_q1.pop_front());
        drive_sources(hold0, hold1);
        if (wb_random) bus.wb_ready = 1'($urandom_range(0, 1));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1; bus.wb_ready = 1'b1;
        bus.in0_rs_id = '0; bus.in0_reg_addr = '0; bus.in0_result = '0; bus.in0_cr0_xer = '0;
        bus.in1_rs_id = '0; bus.in1_reg_addr = '0; bus.in1_result = '0; bus.in1_cr0_xer = '0;
        #1 rst = 1'b1;
        #2;
        sample_out();
        n_cmp++;
        if ({bus.in1_ready, bus.in0_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready act=%b exp=00", {bus.in1_ready, bus.in0_ready});
        end
        n_cmp++;
        if (act_out !== '0) begin
            n_err++; $display("FAIL reset_outputs act=%h exp=0", act_out);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL reset_idle_ready act=%b exp=%b", act_rdy, exp_rdy); end
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL reset_idle_out act=%h exp=%h", act_out, m_out); end
        end
    endtask

    task automatic test_single();
        bus.wb_ready = 1'b1;
        src_q0.push_back(mk(5'd7, 5'd3, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b1));
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL single_ready k=%0d act=%b exp=%b", k, act_rdy, exp_rdy); end
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL single_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            if (k == 0) begin
                n_cmp++;
                if (act_out.gpr_we !== 1'b0) begin n_err++; $display("FAIL single_early_we act=%b exp=0", act_out.gpr_we); end
            end
            if (k == 1) begin
                n_cmp++;
                if ({act_out.gpr_we, act_out.gpr_addr, act_out.gpr_data, act_out.cr0, act_out.done_rs_id, act_out.xer_we}
                    !== {1'b1, 5'd3, 32'hFFFF_FFF0, 4'b1000, 5'd7, 1'b0}) begin
                    n_err++; $display("FAIL single_write act=%h exp we=1 addr=3 data=fffffff0 cr0=1000 tag=7 xer_we=0", act_out);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_addr [5] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd4};
        pulse_reset();
        bus.wb_ready = 1'b1;
        src_q0.push_back(mk(5'd1, 5'd1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0));
        src_q1.push_back(mk(5'd2, 5'd2, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0));
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                src_q0.push_back(mk(5'd4, 5'd4, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0));
                src_q1.push_back(mk(5'd5, 5'd5, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0));
                drive_sources(1'b0, 1'b0);
            end
            cycle();
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL arb_ready k=%0d act=%b exp=%b", k, act_rdy, exp_rdy); end
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL arb_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            if (k == 0 || k == 2) begin
                n_cmp++;
                if (act_rdy !== ((k == 0) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL arb_winner k=%0d act=%b exp=%b", k, act_rdy, (k == 0) ? 2'b01 : 2'b10);
                end
            end
            if (k >= 1) begin
                n_cmp++;
                if ({act_out.gpr_we, act_out.gpr_addr} !== {1'b1, exp_addr[k]}) begin
                    n_err++; $display("FAIL arb_order k=%0d act=%b/%0d exp=1/%0d", k, act_out.gpr_we, act_out.gpr_addr, exp_addr[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) src_q0.push_back(mk(5'(i), 5'(i), 32'(i * 3), 32'h0, 1'b0, 1'b0, 1'b0));
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k == 6) bus.wb_ready = 1'b1;
            cycle();
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL bp_ready k=%0d act=%b exp=%b", k, act_rdy, exp_rdy); end
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL bp_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            if (k >= 4 && k <= 6) begin
                n_cmp++;
                if (act_rdy[0] !== 1'b0) begin n_err++; $display("FAIL bp_full_ready k=%0d act=%b exp=0", k, act_rdy[0]); end
            end
            if (k >= 6 && k <= 10) begin
                n_cmp++;
                if ({act_out.done_valid, act_out.done_rs_id} !== {1'b1, 5'(k - 5)}) begin
                    n_err++; $display("FAIL bp_retire k=%0d act=%b/%0d exp=1/%0d", k, act_out.done_valid, act_out.done_rs_id, k - 5);
                end
            end
        end
    endtask

    task automatic test_zero_xer();
        bus.wb_ready = 1'b1;
        src_q1.push_back(mk(5'd9, 5'd12, 32'h0, 32'h2000_0000, 1'b1, 1'b1, 1'b1));
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL zero_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            if (k == 1) begin
                n_cmp++;
                if ({act_out.cr0, act_out.cr0_we, act_out.xer_we, act_out.xer_data} !== {4'b0011, 1'b1, 1'b1, 32'h2000_0000}) begin
                    n_err++; $display("FAIL zero_cr0_xer act=%b/%b/%b/%h exp=0011/1/1/20000000",
                                      act_out.cr0, act_out.cr0_we, act_out.xer_we, act_out.xer_data);
                end
            end
        end
    endtask

    task automatic test_stream();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_t t = rand_tx();
            t.rs_id = 5'(10 + i);
            src_q1.push_back(t);
        end
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL stream_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            if (k < 8) begin
                n_cmp++;
                if (act_rdy[1] !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d act=%b exp=1", k, act_rdy[1]); end
            end
            n_cmp++;
            if (k >= 1 && k <= 8) begin
                if ({act_out.done_valid, act_out.done_rs_id} !== {1'b1, 5'(9 + k)}) begin
                    n_err++; $display("FAIL stream_pulse k=%0d act=%b/%0d exp=1/%0d", k, act_out.done_valid, act_out.done_rs_id, 9 + k);
                end
            end else if (act_out.gpr_we !== 1'b0) begin
                n_err++; $display("FAIL stream_idle k=%0d act=%b exp=0", k, act_out.gpr_we);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) src_q0.push_back(rand_tx());
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.wb_ready = 1'b1;
            cycle();
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL mid_pre_out k=%0d act=%h exp=%h", k, act_out, m_out); end
        end
        #2 rst = 1'b1;
        #1;
        sample_out();
        n_cmp++;
        if ({act_out, bus.in1_ready, bus.in0_ready} !== '0) begin
            n_err++; $display("FAIL mid_async_clear act=%h rdy=%b%b exp=0", act_out, bus.in1_ready, bus.in0_ready);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                src_q0.push_back(mk(5'd21, 5'd30, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1));
                drive_sources(1'b0, 1'b0);
            end
            cycle();
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL mid_post_out k=%0d act=%h exp=%h", k, act_out, m_out); end
            n_cmp++;
            if (act_out.gpr_we !== (k == 4)) begin
                n_err++; $display("FAIL mid_post_we k=%0d act=%b exp=%b", k, act_out.gpr_we, k == 4);
            end
        end
    endtask

    task automatic test_random();
        int n_tx;
        int n_done;
        n_done = 0;
        start_pct = 60;
        wb_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            src_q0.push_back(rand_tx());
            src_q1.push_back(rand_tx());
        end
        n_tx = 80;
        drive_sources(1'b0, 1'b0);
        for (int k = 0; k < 340; k++) begin
            if (k == 320) begin
                wb_random = 1'b0;
                bus.wb_ready = 1'b1;
            end
            cycle();
            if (act_out.done_valid === 1'b1) n_done++;
            n_cmp++;
            if (act_rdy !== exp_rdy) begin n_err++; $display("FAIL rand_ready k=%0d act=%b exp=%b", k, act_rdy, exp_rdy); end
            n_cmp++;
            if (act_out !== m_out) begin n_err++; $display("FAIL rand_out k=%0d act=%h exp=%h", k, act_out, m_out); end
        end
        n_cmp++;
        if (n_done != n_tx) begin n_err++; $display("FAIL rand_retired act=%0d exp=%0d", n_done, n_tx); end
        start_pct = 100;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_zero_xer();
        test_stream();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Collects completed results from two pipelined execution units, such as the rotate unit and the integer ALU, through their output valid/ready handshakes. It buffers the results in order of acceptance and drives single-ported GPR, CR0 and XER write interfaces. It also returns the reservation-station tag of each retired result so the issuing station can free the entry. The block sits between the execution units and the architectural register files, and is the receiving end of the execution-unit result interface.

## Interface
- RS_ID_WIDTH, 5, width of reservation-station tag
- DEPTH, 4, buffer entries; power of two, >= 2
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in0_valid  in  1  result from source 0 valid
- in0_ready  out  1  source 0 result accepted this cycle when high with in0_valid
- in0_rs_id  in  RS_ID_WIDTH  tag of source 0 result
- in0_reg_addr  in  5  target GPR of source 0
- in0_result  in  32  result data, bit 0 = MSB
- in0_cr0_xer  in  cond_exception_t  fields used: xer[0:31], xer_valid, so, CR0_valid
- in1_valid, in1_ready, in1_rs_id, in1_reg_addr, in1_result, in1_cr0_xer: same as source 0
- wb_ready  in  1  register files accept a write this cycle
- gpr_we  out  1  GPR write strobe
- gpr_addr  out  5  GPR write address
- gpr_data  out  32  GPR write data
- cr0_we  out  1  CR field 0 write strobe
- cr0  out  4  [0]=LT, [1]=GT, [2]=EQ, [3]=SO
- xer_we  out  1  XER write strobe
- xer_data  out  32  XER write data
- done_valid  out  1  tag release strobe
- done_rs_id  out  RS_ID_WIDTH  released tag

## Operation
- Ingress arbitration:
  - inX_ready = ~full & (~in_other_valid | prio == X). Ready depends only on occupancy, peer valid and prio; there is no path from wb_ready.
  - At most one push per cycle.
  - prio is a 1-bit register, reset 0. It toggles only on a cycle where both valid are high and a push occurs. It then points to the loser.
- CR0 is computed at push from the incoming result:
  - LT = result[0]
  - GT = ~result[0] & (result != 0)
  - EQ = (result == 0)
  - SO = cr0_xer.so
- Each entry stores rs_id, reg_addr, result, computed CR0, CR0_valid, xer, xer_valid.
- Buffer: circular, DEPTH entries, read/write pointers of log2(DEPTH) bits that wrap. Occupancy counter is log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- Pop condition: ~empty & wb_ready. On pop, output registers load the head entry:
  - gpr_we=1, gpr_addr, gpr_data
  - cr0_we=CR0_valid, cr0
  - xer_we=xer_valid, xer_data=xer
  - done_valid=1, done_rs_id
- On a cycle with no pop, all strobes register 0. Address and data registers hold their last value.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, a push is refused even if a pop occurs in the same cycle.
- Ordering: retirement order equals acceptance order. There is no reordering between sources.
- Reset (async, any time):
  - count, pointers and prio go to 0; buffered entries are discarded.
  - All outputs go to 0 immediately, including in0_ready and in1_ready while rst is high.

## Timing
- Handshake accepted at edge N. Earliest pop is at edge N+1, so strobes are visible after edge N+1. Result-to-write latency is 2 cycles.
- Strobes are one-cycle pulses per pop. Back-to-back pops hold strobes high with new data each cycle.
- Sustained throughput: 1 result/cycle with wb_ready constantly high.
- wb_ready low: strobes go 0 at the next edge and entries stay buffered. Ingress continues until full.
- From empty with simultaneous push: wb_ready has no effect that cycle, since the push lands at the edge.
- Sources must hold valid and payload stable until ready, which is the execution-unit output convention.

## Test plan
- **Single result, negative:** in0_valid=1 with result=0xFFFF_FFF0, reg_addr=3, rs_id=7, CR0_valid=1, so=0, wb_ready=1. Required: 2 cycles later gpr_we=1, gpr_addr=3, gpr_data=0xFFFF_FFF0, cr0=1000, done_rs_id=7, xer_we=0.
- **Arbitration:** in0 and in1 valid together after reset, payloads reg 1 and reg 2, held. Required: in0 accepted first, in1 the next cycle, writes to reg 1 then reg 2. Then both valid again: in1 wins, because prio=1.
- **Backpressure and full:** wb_ready=0; push 5 results with tags 1..5. Required: in0_ready drops after the 4th; tag 5 is held off. Raise wb_ready: tags 1..4 retire on 4 consecutive cycles, tag 5 is accepted after the first pop and retires 5th.
- **Zero result with XER:** result=0, so=1, CR0_valid=1, xer_valid=1, xer=0x2000_0000. Required: cr0=0011, cr0_we=1, xer_we=1, xer_data=0x2000_0000.
- **Simultaneous push and pop:** continuous in1 stream of 8 results with wb_ready=1. Required: count stays at most 1, 8 consecutive write pulses in order, pointers wrap cleanly past DEPTH.
- **Reset mid-operation:** assert rst with 3 entries buffered. Required: all strobes and readies are 0 without waiting for a clock edge. After release no stale writes occur, and the first new result retires 2 cycles after acceptance.
